// File: rtl/pipe_addsub_rca_pkg.sv
// pipe_rca_pkg: chunk geometry helpers for the pipelined ripple-carry adder/subtractor
// Functions: chunk_width (bits per stage), chunk_lo/chunk_hi (bit bounds of chunk k)
package pipe_rca_pkg;

  function automatic int chunk_width(input int w, input int stages);
    return (w + stages - 1) / stages;
  endfunction

  function automatic int chunk_lo(input int k, input int cw);
    return k * cw;
  endfunction

  function automatic int chunk_hi(input int k, input int cw, input int w);
    return (((k + 1) * cw < w) ? (k + 1) * cw : w) - 1;
  endfunction

endpackage

// File: rtl/pipe_addsub_rca_if.sv
// pipe_addsub_rca_if: operand/result handshake bundle for pipe_addsub_rca
// master: in_valid, a, b, sub, out_ready out; in_ready, out_valid, out in
// slave:  mirror of master
interface pipe_addsub_rca_if #(parameter int N = 6);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out;
  modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, out);
  modport slave (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/pipe_addsub_rca_chunk.sv
// rca_chunk: CW-bit combinational ripple-carry adder built from full adders
// Ports: x, y (operand chunks), cin (carry in), sum (chunk sum), cout (carry out)
module rca_chunk
  import pipe_rca_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);
  logic [CW:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout = c[CW];
endmodule

// File: rtl/pipe_addsub_rca.sv
// pipe_addsub_rca: pipelined N+1-bit ripple-carry add/subtract with valid/ready flow control
// Ports: clk, rst_n (sync active-low), bus (slave: in_valid/in_ready/a/b/sub in, out_valid/out_ready/out)
module pipe_addsub_rca
  import pipe_rca_pkg::*;
#(
  parameter int N      = 6,
  parameter int STAGES = 3,
  parameter bit SIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_addsub_rca_if.slave bus
);
  localparam int W  = N + 1;
  localparam int CW = chunk_width(W, STAGES);
  if (STAGES < 1 || STAGES > W || chunk_lo(STAGES - 1, CW) >= W) begin : g_bad
    $error("pipe_addsub_rca: STAGES out of range or leaves an empty chunk");
  end
  logic         en;
  logic [W-1:0] a_ext, b_ext;
  logic         v_q  [STAGES];
  logic         cy_q [STAGES];
  logic [W-1:0] a_q  [STAGES];
  logic [W-1:0] b_q  [STAGES];
  logic [W-1:0] s_q  [STAGES];
  // A single global enable: a stalled output freezes every stage, bubbles included.
  assign en            = ~v_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out       = s_q[STAGES-1];
  assign a_ext = {SIGNED & bus.a[N-1], bus.a};
  // Subtraction as a + ~b + 1: the +1 enters as the stage-0 carry-in.
  assign b_ext = {SIGNED & bus.b[N-1], bus.b} ^ {W{bus.sub}};
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = chunk_lo(k, CW);
    localparam int HI = chunk_hi(k, CW, W);
    logic [HI-LO:0] x, y, sum;
    logic           v_in, ci, co;
    logic [W-1:0]   a_in, b_in, s_in, s_d;
    if (k == 0) begin : g_head
      assign {v_in, ci, a_in, b_in, s_in} = {bus.in_valid, bus.sub, a_ext, b_ext, {W{1'b0}}};
    end else begin : g_body
      assign {v_in, ci, a_in, b_in, s_in} = {v_q[k-1], cy_q[k-1], a_q[k-1], b_q[k-1], s_q[k-1]};
    end
    assign x = a_in[HI:LO];
    assign y = b_in[HI:LO];
    rca_chunk #(.CW(HI - LO + 1)) u_rca (
      .x    (x),
      .y    (y),
      .cin  (ci),
      .sum  (sum),
      .cout (co)
    );
    // Lower chunks ride along from earlier stages; this stage fills in its own slice.
    always_comb begin
      s_d        = s_in;
      s_d[HI:LO] = sum;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q[k]  <= 1'b0;
        cy_q[k] <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
      end else if (en) begin
        v_q[k]  <= v_in;
        cy_q[k] <= co;
        a_q[k]  <= a_in;
        b_q[k]  <= b_in;
        s_q[k]  <= s_d;
      end
    end
  end
endmodule

// File: tb/tb_pipe_addsub_rca.sv
// tb_pipe_addsub_rca: directed-vector and scoreboard bench over four pipe_addsub_rca configurations
// Instances: d0 N6/S3/signed, d1 N6/S2/unsigned, d2 N6/S1/unsigned, d3 N6/S7/signed
module tb_pipe_addsub_rca;
  typedef struct packed {
    logic [1:0] d;
    logic [5:0] a;
    logic [5:0] b;
    logic       s;
    logic [6:0] e;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv [4];
  logic       is [4];
  logic       ordy [4];
  logic       irdy [4];
  logic       ov [4];
  logic [5:0] ia [4];
  logic [5:0] ib [4];
  logic [6:0] od [4];
  int         total = 0;
  int         bad = 0;
  vec_t       tv [15];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_d
    pipe_addsub_rca_if #(.N(6)) bus ();
    assign bus.in_valid  = iv[g];
    assign bus.a         = ia[g];
    assign bus.b         = ib[g];
    assign bus.sub       = is[g];
    assign bus.out_ready = ordy[g];
    assign irdy[g]       = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign od[g]         = bus.out;
    pipe_addsub_rca #(
      .N      (6),
      .STAGES (g == 0 ? 3 : g == 1 ? 2 : g == 2 ? 1 : 7),
      .SIGNED (g == 0 || g == 3)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end
  function automatic int stg(input int d);
    return d == 0 ? 3 : d == 1 ? 2 : d == 2 ? 1 : 7;
  endfunction
  function automatic logic [6:0] ref_f(input logic [5:0] a, input logic [5:0] b, input logic s, input logic sg);
    int ai = sg ? int'($signed(a)) : int'(a);
    int bi = sg ? int'($signed(b)) : int'(b);
    return 7'(s ? ai - bi : ai + bi);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  // Cycle 0 presents the beat; lat counts cycles until out_valid is seen.
  task automatic one(input int d, input logic [5:0] a, input logic [5:0] b, input logic s,
                     output logic [6:0] r, output int lat);
    @(negedge clk);
    ia[d] = a;
    ib[d] = b;
    is[d] = s;
    iv[d] = 1'b1;
    #1;
    chk("in_ready_idle", irdy[d], 1);
    @(negedge clk);
    iv[d] = 1'b0;
    lat = 1;
    while (!ov[d] && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    r = od[d];
  endtask
  // Beats i: a=i, b=2i, sub=i[0]; output held off for `stall` cycles once it first becomes valid.
  task automatic stream(input int n, input int stall);
    int sent = 0, got = 0, first = -1, last = -1, stalled = 0;
    bit prev_st = 1'b0;
    logic [6:0] prev_o = '0, e;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      ordy[0] = !(ov[0] && stalled < stall);
      if (!ordy[0]) stalled++;
      iv[0] = sent < n;
      ia[0] = 6'(sent);
      ib[0] = 6'(2 * sent);
      is[0] = sent[0];
      #1;
      if (prev_st) chk("stall_hold", {ov[0], od[0]}, {1'b1, prev_o});
      chk("in_ready", irdy[0], ordy[0] ? 1 : 0);
      prev_st = !ordy[0];
      prev_o = od[0];
      if (ov[0] && ordy[0]) begin
        e = got[0] ? 7'(-got) : 7'(3 * got);
        chk("stream_out", od[0], e);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (iv[0] && irdy[0]) sent++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("stream_count", got, n);
    if (stall == 0) chk("stream_consecutive", last - first, n - 1);
  endtask
  task automatic rnd(input int d, input int n);
    logic [6:0] q[$];
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
      cyc++;
      ordy[d] = $urandom_range(0, 3) != 0;
      iv[d] = sent < n && $urandom_range(0, 3) != 0;
      ia[d] = 6'($urandom);
      ib[d] = 6'($urandom);
      is[d] = 1'($urandom);
      #1;
      if (ov[d] && ordy[d]) begin
        if (q.size() == 0) chk("rnd_spurious", 1, 0);
        else chk("rnd_out", od[d], q.pop_front());
        got++;
      end
      if (iv[d] && irdy[d]) begin
        q.push_back(ref_f(ia[d], ib[d], is[d], d == 3));
        sent++;
      end
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    chk("rnd_count", got, n);
  endtask
  initial begin
    logic [6:0] r;
    int lat, cnt;
    tv = '{
      '{2'd0, 6'd20,  6'd28,  1'b0, 7'h30},
      '{2'd0, 6'h20,  6'h20,  1'b0, 7'h40},
      '{2'd0, 6'h20,  6'h1f,  1'b1, 7'h41},
      '{2'd0, 6'h1f,  6'h1f,  1'b0, 7'h3e},
      '{2'd0, 6'h3f,  6'h01,  1'b0, 7'h00},
      '{2'd0, 6'd5,   6'd10,  1'b1, 7'h7b},
      '{2'd0, 6'h1f,  6'h20,  1'b1, 7'h3f},
      '{2'd1, 6'h3f,  6'h3f,  1'b0, 7'h7e},
      '{2'd1, 6'h00,  6'h3f,  1'b1, 7'h41},
      '{2'd1, 6'h3f,  6'h00,  1'b1, 7'h3f},
      '{2'd1, 6'h10,  6'h20,  1'b1, 7'h70},
      '{2'd2, 6'h3f,  6'h01,  1'b0, 7'h40},
      '{2'd3, 6'h3f,  6'h3f,  1'b1, 7'h00},
      '{2'd3, 6'h20,  6'h01,  1'b1, 7'h5f},
      '{2'd3, 6'h1f,  6'h1f,  1'b0, 7'h3e}
    };
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      is[i] = 1'b0;
      ordy[i] = 1'b1;
      ia[i] = '0;
      ib[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) chk("reset_state", {ov[i], od[i], irdy[i]}, {1'b0, 7'h00, 1'b1});
    for (int i = 0; i < 15; i++) begin
      one(int'(tv[i].d), tv[i].a, tv[i].b, tv[i].s, r, lat);
      chk("vec_out", r, tv[i].e);
      chk("vec_lat", lat, stg(int'(tv[i].d)));
    end
    stream(8, 0);
    stream(5, 2);
    @(negedge clk);
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      ia[0] = 6'(i + 1);
      ib[0] = 6'(i + 1);
      is[0] = 1'b0;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    chk("rst_inflight", ov[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_clear", {ov[0], od[0], irdy[0]}, {1'b0, 7'h00, 1'b1});
    ordy[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0]) cnt++;
    end
    chk("rst_no_stale", cnt, 0);
    rnd(2, 1000);
    rnd(3, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
